// File: rtl/tea_loader.sv
// Word-stream front end for a TEA core: loads V0,V1,K0..K3, starts the core and streams back the result pair.
// Optional build macro TEA_LOADER_KEY_REUSE_EN adds iKeepKey for two-word blocks that reuse the previous key.
module tea_loader #(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] iWord,
  input  logic                 iWordValid,
  output logic                 oWordReady,
  input  logic                 iMode,
`ifdef TEA_LOADER_KEY_REUSE_EN
  input  logic                 iKeepKey,
`endif
  output logic [WORD_SIZE-1:0] oV0,
  output logic [WORD_SIZE-1:0] oV1,
  output logic [WORD_SIZE-1:0] oK0,
  output logic [WORD_SIZE-1:0] oK1,
  output logic [WORD_SIZE-1:0] oK2,
  output logic [WORD_SIZE-1:0] oK3,
  output logic                 oStartCipher,
  output logic                 oStartDecipher,
  input  logic                 iDoneCipher,
  input  logic                 iDoneDecipher,
  input  logic [WORD_SIZE-1:0] iC0,
  input  logic [WORD_SIZE-1:0] iC1,
  input  logic [WORD_SIZE-1:0] iP0,
  input  logic [WORD_SIZE-1:0] iP1,
  output logic [WORD_SIZE-1:0] oResult,
  output logic                 oResultValid,
  input  logic                 iResultReady,
  output logic                 oBusy
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    UNLOAD0 = 3'd4,
    UNLOAD1 = 3'd5
  } state_t;

  state_t               state;
  state_t               stateNext;
  logic [CNT_W-1:0]     wordCnt;
  logic                 modeQ;
  logic [WORD_SIZE-1:0] r0;
  logic [WORD_SIZE-1:0] r1;
  logic                 wordXfer;
  logic                 lastWord;
  logic                 doneSel;

  assign wordXfer = iWordValid && oWordReady;
  // Only the done flag of the mode this block was loaded with counts.
  assign doneSel  = modeQ ? iDoneDecipher : iDoneCipher;

`ifdef TEA_LOADER_KEY_REUSE_EN
  logic keepKeyQ;
  assign lastWord = (wordCnt == CNT_W'(5)) || (keepKeyQ && (wordCnt == CNT_W'(1)));
`else
  assign lastWord = (wordCnt == CNT_W'(5));
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (wordXfer)             stateNext = LOAD;
      LOAD:    if (wordXfer && lastWord) stateNext = START;
      START:                             stateNext = WAIT;
      WAIT:    if (doneSel)              stateNext = UNLOAD0;
      UNLOAD0: if (iResultReady)         stateNext = UNLOAD1;
      UNLOAD1: if (iResultReady)         stateNext = IDLE;
      default:                           stateNext = IDLE;
    endcase
  end

  // Outputs decoded from the registered state; ready is also held low during reset
  always_comb begin
    oWordReady     = 1'b0;
    oStartCipher   = 1'b0;
    oStartDecipher = 1'b0;
    oResultValid   = 1'b0;
    oResult        = '0;
    oBusy          = (state != IDLE);
    unique case (state)
      IDLE, LOAD: oWordReady = rst;
      START: begin
        oStartCipher   = !modeQ;
        oStartDecipher = modeQ;
      end
      UNLOAD0: begin
        oResultValid = 1'b1;
        oResult      = r0;
      end
      UNLOAD1: begin
        oResultValid = 1'b1;
        oResult      = r1;
      end
      default: ;
    endcase
  end

  // Operand loading, mode latch and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wordCnt <= '0;
      modeQ   <= 1'b0;
      oV0     <= '0;
      oV1     <= '0;
      oK0     <= '0;
      oK1     <= '0;
      oK2     <= '0;
      oK3     <= '0;
      r0      <= '0;
      r1      <= '0;
`ifdef TEA_LOADER_KEY_REUSE_EN
      keepKeyQ <= 1'b0;
`endif
    end else begin
      if (wordXfer) begin
        if (state == IDLE) begin
          oV0     <= iWord;
          modeQ   <= iMode;
          wordCnt <= CNT_W'(1);
`ifdef TEA_LOADER_KEY_REUSE_EN
          keepKeyQ <= iKeepKey;
`endif
        end else begin
          unique case (wordCnt)
            CNT_W'(1): oV1 <= iWord;
            CNT_W'(2): oK0 <= iWord;
            CNT_W'(3): oK1 <= iWord;
            CNT_W'(4): oK2 <= iWord;
            CNT_W'(5): oK3 <= iWord;
            default: ;
          endcase
          // Counter parks on the last word so it never passes 5
          if (!lastWord) wordCnt <= wordCnt + CNT_W'(1);
        end
      end
      if ((state == WAIT) && doneSel) begin
        r0 <= modeQ ? iP0 : iC0;
        r1 <= modeQ ? iP1 : iC1;
      end
      if ((state == UNLOAD1) && iResultReady) wordCnt <= '0;
    end
  end

endmodule
